// File: rtl/noc_pkg.sv
// Shared definitions for the NoC packet checker.
// Header field offsets, error bit indices, FSM encodings and LFSR constants.
package noc_pkg;

    localparam int DX_LSB  = 28;
    localparam int DY_LSB  = 24;
    localparam int SX_LSB  = 20;
    localparam int SY_LSB  = 16;
    localparam int LEN_LSB = 8;
    localparam int SEQ_LSB = 0;

    localparam int ERR_PROTO = 0;
    localparam int ERR_DEST  = 1;
    localparam int ERR_LEN   = 2;
    localparam int ERR_PAY   = 3;
    localparam int ERR_SEQ   = 4;

    localparam logic [4:0] E_PROTO = 5'(1 << ERR_PROTO);
    localparam logic [4:0] E_DEST  = 5'(1 << ERR_DEST);
    localparam logic [4:0] E_LEN   = 5'(1 << ERR_LEN);
    localparam logic [4:0] E_PAY   = 5'(1 << ERR_PAY);
    localparam logic [4:0] E_SEQ   = 5'(1 << ERR_SEQ);

    // x^8 + x^6 + x^5 + x^4 + 1, left-shifting Fibonacci form
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        S_HEAD  = 2'd0,
        S_BODY  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    function automatic logic [15:0] sat_add(input logic [15:0] c,
                                            input logic [1:0]  inc);
        logic [16:0] s;
        s = {1'b0, c} + 17'(inc);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/noc_ready_lfsr.sv
// Pseudo-random backpressure generator for the packet checker.
// Ready is forced low in reset and high when stalling is disabled.
module noc_ready_lfsr
    import noc_pkg::*;
(
    input  logic noc_clk,
    input  logic noc_rst,
    input  logic stall_en,
    output logic ready
);

    logic [7:0] lfsr;

    // Advance the shift register only while stalling is enabled
    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            lfsr <= LFSR_SEED;
        end else if (stall_en) begin
            lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    assign ready = !noc_rst && (!stall_en || lfsr[0] || lfsr[1]);

endmodule

// File: rtl/noc_packet_checker.sv
// Receive-side NoC packet checker: validates headers, payload, length
// and per-source sequence numbers, and counts good and bad packets.
module noc_packet_checker
    import noc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int X_ID   = 1,
    parameter int Y_ID   = 1
) (
    input  logic              noc_clk,
    input  logic              noc_rst,
    input  logic              receive_valid,
    output logic              receive_ready,
    input  logic [DATA_W-1:0] receive_flit,
    input  logic              receive_is_header,
    input  logic              receive_is_tail,
    input  logic              stall_en,
    output logic [15:0]       receive_num,
    output logic [15:0]       err_num,
    output logic [4:0]        err_flags,
    output logic              pkt_done,
    output logic              pkt_ok
);

    state_t      state, state_n;
    logic [7:0]  len_q, len_n;
    logic [7:0]  seq_q, seq_n;
    logic [7:0]  idx_q, idx_n;
    logic [4:0]  cur_q, cur_n;
    logic [7:0]  seq_tbl [4];

    logic        xfer;
    logic [1:0]  h_src;
    logic [7:0]  h_len;
    logic [7:0]  h_seq;
    logic        dest_bad;
    logic [4:0]  h_err;
    logic        body_last;
    logic [4:0]  body_err;
    logic        take_hdr;
    logic        fin;
    logic [4:0]  fin_err;
    logic        abort;
    logic [1:0]  good_inc;
    logic [1:0]  bad_inc;

    noc_ready_lfsr u_lfsr (
        .noc_clk  (noc_clk),
        .noc_rst  (noc_rst),
        .stall_en (stall_en),
        .ready    (receive_ready)
    );

    assign xfer     = receive_valid && receive_ready;
    assign h_src    = {receive_flit[SX_LSB], receive_flit[SY_LSB]};
    assign h_len    = receive_flit[LEN_LSB +: 8];
    assign h_seq    = receive_flit[SEQ_LSB +: 8];
    assign dest_bad = (receive_flit[DX_LSB +: 4] != 4'(X_ID)) ||
                      (receive_flit[DY_LSB +: 4] != 4'(Y_ID));
    assign h_err    = (dest_bad ? E_DEST : 5'd0) |
                      ((h_seq != seq_tbl[h_src]) ? E_SEQ : 5'd0);

    assign body_last = (idx_q == len_q - 8'd1);
    assign body_err  = cur_q |
                       ((receive_flit != DATA_W'({seq_q, idx_q})) ?
                        E_PAY : 5'd0);

    // Next-state, packet-end and error classification for the current flit
    always_comb begin
        state_n  = state;
        len_n    = len_q;
        seq_n    = seq_q;
        idx_n    = idx_q;
        cur_n    = cur_q;
        take_hdr = 1'b0;
        fin      = 1'b0;
        fin_err  = 5'd0;
        abort    = 1'b0;
        unique case (state)
            S_HEAD: begin
                if (xfer) begin
                    if (receive_is_header) begin
                        take_hdr = 1'b1;
                    end else if (receive_is_tail) begin
                        fin     = 1'b1;
                        fin_err = E_PROTO;
                    end else begin
                        state_n = S_DRAIN;
                        cur_n   = E_PROTO;
                    end
                end
            end
            S_BODY: begin
                if (xfer) begin
                    if (receive_is_header) begin
                        abort    = 1'b1;
                        take_hdr = 1'b1;
                    end else if (receive_is_tail) begin
                        fin     = 1'b1;
                        fin_err = body_err | (body_last ? 5'd0 : E_LEN);
                        state_n = S_HEAD;
                    end else if (body_last) begin
                        cur_n   = body_err | E_LEN;
                        state_n = S_DRAIN;
                    end else begin
                        cur_n = body_err;
                        idx_n = idx_q + 8'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (xfer && receive_is_tail) begin
                    fin     = 1'b1;
                    fin_err = cur_q;
                    state_n = S_HEAD;
                end
            end
            default: state_n = S_HEAD;
        endcase
        if (take_hdr) begin
            len_n = h_len;
            seq_n = h_seq;
            idx_n = 8'd0;
            if (h_len == 8'd0) begin
                if (receive_is_tail) begin
                    fin     = 1'b1;
                    fin_err = h_err;
                    state_n = S_HEAD;
                end else begin
                    cur_n   = h_err | E_LEN;
                    state_n = S_DRAIN;
                end
            end else if (receive_is_tail) begin
                fin     = 1'b1;
                fin_err = h_err | E_LEN;
                state_n = S_HEAD;
            end else begin
                cur_n   = h_err;
                state_n = S_BODY;
            end
        end
    end

    // An aborting header can close two packets in one cycle; both are counted
    assign good_inc = 2'(fin && (fin_err == 5'd0));
    assign bad_inc  = 2'(abort) + 2'(fin && (fin_err != 5'd0));

    // Packet-tracking state and per-source sequence table
    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            state <= S_HEAD;
            len_q <= 8'd0;
            seq_q <= 8'd0;
            idx_q <= 8'd0;
            cur_q <= 5'd0;
            for (int i = 0; i < 4; i++) seq_tbl[i] <= 8'd0;
        end else begin
            state <= state_n;
            len_q <= len_n;
            seq_q <= seq_n;
            idx_q <= idx_n;
            cur_q <= cur_n;
            if (take_hdr) seq_tbl[h_src] <= h_seq + 8'd1;
        end
    end

    // Packet-end reporting, counters and sticky error flags
    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            receive_num <= 16'd0;
            err_num     <= 16'd0;
            err_flags   <= 5'd0;
            pkt_done    <= 1'b0;
            pkt_ok      <= 1'b0;
        end else begin
            receive_num <= sat_add(receive_num, good_inc);
            err_num     <= sat_add(err_num, bad_inc);
            err_flags   <= err_flags |
                           (fin ? fin_err : 5'd0) |
                           (abort ? (cur_q | E_PROTO) : 5'd0);
            pkt_done    <= fin || abort;
            pkt_ok      <= fin && (fin_err == 5'd0) && !abort;
        end
    end

endmodule
